// File: rtl/vga_pkg.sv
// Shared timing defaults, FSM states and coordinate type for the VGA receiver.
package vga_pkg;
  localparam int H_TOTAL_DEF  = 800;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_TOTAL_DEF  = 525;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [9:0] coord_t;
  localparam coord_t CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_edge_det.sv
// Input register stage with rise/fall detection against one further delay stage.
module vga_edge_det #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      q_d <= '0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/vga_rx.sv
// VGA receiver: validates 640x480 timing, locks, and emits a framebuffer write stream.
// Optional per-frame checksum on frame_sum when VGA_RX_FRAME_SUM_EN is defined.
module vga_rx
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        pix_we,
  output logic        locked,
  output logic        frame_done,
  output logic [7:0]  err_cnt,
  output logic [23:0] frame_sum
);
  localparam coord_t HT    = coord_t'(H_TOTAL);
  localparam coord_t HA    = coord_t'(H_ACTIVE);
  localparam coord_t VT    = coord_t'(V_TOTAL);
  localparam coord_t VA    = coord_t'(V_ACTIVE);
  localparam coord_t X_MAX = coord_t'(H_ACTIVE - 1);

  // bit 0 hsync, bit 1 vsync, bit 2 valid
  logic [2:0] sq, srise, sfall;
  logic       unused_edge;

  vga_edge_det #(.W(3)) u_edge (
    .clk   (pclk),
    .reset (reset),
    .d     ({valid, vsync, hsync}),
    .q     (sq),
    .rise  (srise),
    .fall  (sfall)
  );
  assign unused_edge = ^{srise[1:0], sq[1:0]};

  logic ls, fs, vq, vrise, vfall;
  assign ls    = sfall[0];
  assign fs    = sfall[1];
  assign vq    = sq[2];
  assign vrise = srise[2];
  assign vfall = sfall[2];

  state_t      state, next;
  coord_t      lcnt, acnt, vlcnt, alcnt, y_cnt;
  logic        mm_flag, first_line;
  logic [23:0] rgb_q;
  logic        mm_now, fd_now, first_valid, enter;

  assign first_valid = vq && (ls || acnt == '0);
  assign enter       = (state == HUNT) && fs;

  // Out-of-range coordinates count as mismatches so they are never written.
  assign mm_now = (lcnt == CNT_MAX)
                | (ls && !first_line && (lcnt != HT || (acnt != '0 && acnt != HA)))
                | (fs && (vlcnt != VT || alcnt != VA))
                | (vq && !vrise && pix_x == X_MAX)
                | (vq && y_cnt >= VA);

  assign fd_now = (state == LOCKED) && fs && !mm_now;

  always_comb begin
    next = state;
    case (state)
      HUNT:    if (fs) next = CHECK;
      CHECK:   if (fs && !mm_flag && !mm_now) next = LOCKED;
      LOCKED:  if (mm_now) next = HUNT;
      default: next = HUNT;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= HUNT;
      lcnt       <= '0;
      acnt       <= '0;
      vlcnt      <= '0;
      alcnt      <= '0;
      y_cnt      <= '0;
      mm_flag    <= 1'b0;
      first_line <= 1'b0;
      rgb_q      <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      pix_we     <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state <= next;
      rgb_q <= {vga_r, vga_g, vga_b};

      if (enter)   lcnt <= '0;
      else if (ls) lcnt <= 10'd1;
      else         lcnt <= sat_inc(lcnt);

      if (enter)   acnt <= '0;
      else if (ls) acnt <= vq ? 10'd1 : 10'd0;
      else if (vq) acnt <= sat_inc(acnt);

      if (fs)      vlcnt <= ls ? 10'd1 : 10'd0;
      else if (ls) vlcnt <= sat_inc(vlcnt);

      if (fs)               alcnt <= first_valid ? 10'd1 : 10'd0;
      else if (first_valid) alcnt <= sat_inc(alcnt);

      // y_cnt is the row the next valid run belongs to; pix_y follows it on writes
      if (fs)         y_cnt <= '0;
      else if (vfall) y_cnt <= sat_inc(y_cnt);

      if (vq) begin
        if (vrise)              pix_x <= '0;
        else if (pix_x != X_MAX) pix_x <= pix_x + 10'd1;
      end

      if (fs)                   pix_y <= '0;
      else if (vq && y_cnt < VA) pix_y <= y_cnt;

      mm_flag    <= (state == CHECK && !fs) ? (mm_flag | mm_now) : 1'b0;
      first_line <= enter ? 1'b1 : (ls ? 1'b0 : first_line);

      pix_data   <= rgb_q;
      pix_we     <= (next == LOCKED) && vq;
      locked     <= (next == LOCKED);
      frame_done <= fd_now;

      if (state == LOCKED && mm_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef VGA_RX_FRAME_SUM_EN
  logic [23:0] acc, acc_nxt;
  assign acc_nxt = acc + (pix_we ? pix_data : 24'd0);

  always_ff @(posedge pclk) begin
    if (reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      acc <= fs ? 24'd0 : acc_nxt;
      if (fd_now) frame_sum <= acc_nxt;
    end
  end
`else
  assign frame_sum = 24'd0;
`endif
endmodule
